// File: rtl/avoid_motor_drive.sv
// Dual H-bridge PWM driver for the obstacle-avoidance path: per-wheel duty ramping
// with a coast dead-time on every direction reversal.
module avoid_motor_drive #(
    parameter int CLK_FREQ     = 50000000,
    parameter int PWM_FREQ     = 1000,
    parameter int DUTY_FWD     = 70,
    parameter int DUTY_TURN    = 50,
    parameter int RAMP_STEP    = 5,
    parameter int DEAD_PERIODS = 20
) (
    input  logic       clk,
    input  logic       nCR,
    input  logic       enable,
    input  logic [1:0] AvoidSignal,
    output logic [1:0] motor_l,
    output logic [1:0] motor_r,
    output logic       moving
);
    localparam int PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int UNIT   = PERIOD / 100;
    localparam int TH_W   = $clog2(PERIOD + 1);
    localparam int DEAD_W = (DEAD_PERIODS < 1) ? 1 : $clog2(DEAD_PERIODS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DOWN, DEAD} state_t;

    logic [TH_W-1:0]   cnt_q, cnt_d;
    state_t            state_q [2];
    state_t            state_d [2];
    logic [6:0]        duty_q  [2];
    logic [6:0]        duty_d  [2];
    logic              dir_q   [2];
    logic              dir_d   [2];
    logic [DEAD_W-1:0] dead_q  [2];
    logic [DEAD_W-1:0] dead_d  [2];
    logic [1:0]        motor_q [2];
    logic [1:0]        motor_d [2];
    logic              moving_q, moving_d;

    logic              boundary;
    logic [6:0]        tgt_duty;
    logic              tgt_dir [2];
    logic [TH_W-1:0]   thr     [2];
    logic              pwm     [2];

    function automatic logic [6:0] ramp_toward(input logic [6:0] cur, input logic [6:0] tgt);
        logic [7:0] up;
        up = {1'b0, cur} + 8'(RAMP_STEP);
        if (cur < tgt)
            return (up >= {1'b0, tgt}) ? tgt : up[6:0];
        else if ((cur - tgt) <= 7'(RAMP_STEP))
            return tgt;
        else
            return cur - 7'(RAMP_STEP);
    endfunction

    function automatic logic [6:0] step_down(input logic [6:0] cur);
        return (cur <= 7'(RAMP_STEP)) ? 7'd0 : cur - 7'(RAMP_STEP);
    endfunction

    // Disabled: aim for zero in the current direction so no reversal is triggered.
    always_comb begin
        tgt_duty   = (AvoidSignal == 2'b00) ? 7'(DUTY_FWD) : 7'(DUTY_TURN);
        tgt_dir[0] = AvoidSignal[0];
        tgt_dir[1] = AvoidSignal[1];
        if (!enable) begin
            tgt_duty   = 7'd0;
            tgt_dir[0] = dir_q[0];
            tgt_dir[1] = dir_q[1];
        end
    end

    always_comb begin
        boundary = (cnt_q == TH_W'(PERIOD - 1));
        cnt_d    = boundary ? '0 : cnt_q + TH_W'(1);
        moving_d = (duty_q[0] != 7'd0) || (duty_q[1] != 7'd0);
        for (int w = 0; w < 2; w++) begin
            state_d[w] = state_q[w];
            duty_d[w]  = duty_q[w];
            dir_d[w]   = dir_q[w];
            dead_d[w]  = dead_q[w];
            thr[w]     = TH_W'(32'(duty_q[w]) * UNIT);
            pwm[w]     = (cnt_q < thr[w]);
            motor_d[w] = 2'b00;
            if ((state_q[w] == RUN || state_q[w] == DOWN) && pwm[w])
                motor_d[w] = dir_q[w] ? 2'b01 : 2'b10;

            if (boundary) begin
                unique case (state_q[w])
                    IDLE: begin
                        if (tgt_duty != 7'd0) begin
                            dir_d[w]   = tgt_dir[w];
                            duty_d[w]  = ramp_toward(7'd0, tgt_duty);
                            state_d[w] = RUN;
                        end
                    end
                    RUN, DOWN: begin
                        // Same direction (also a revert while slowing down): ramp to target.
                        if (tgt_dir[w] == dir_q[w]) begin
                            duty_d[w]  = ramp_toward(duty_q[w], tgt_duty);
                            state_d[w] = (duty_d[w] == 7'd0) ? IDLE : RUN;
                        end else begin
                            duty_d[w] = step_down(duty_q[w]);
                            if (duty_d[w] == 7'd0) begin
                                state_d[w] = DEAD;
                                dead_d[w]  = DEAD_W'(DEAD_PERIODS);
                            end else begin
                                state_d[w] = DOWN;
                            end
                        end
                    end
                    DEAD: begin
                        if (dead_q[w] <= DEAD_W'(1)) begin
                            dead_d[w] = '0;
                            dir_d[w]  = tgt_dir[w];
                            if (tgt_duty != 7'd0) begin
                                duty_d[w]  = ramp_toward(7'd0, tgt_duty);
                                state_d[w] = RUN;
                            end else begin
                                state_d[w] = IDLE;
                            end
                        end else begin
                            dead_d[w] = dead_q[w] - DEAD_W'(1);
                        end
                    end
                    default: state_d[w] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            cnt_q    <= '0;
            moving_q <= 1'b0;
            for (int w = 0; w < 2; w++) begin
                state_q[w] <= IDLE;
                duty_q[w]  <= 7'd0;
                dir_q[w]   <= 1'b0;
                dead_q[w]  <= '0;
                motor_q[w] <= 2'b00;
            end
        end else begin
            cnt_q    <= cnt_d;
            moving_q <= moving_d;
            for (int w = 0; w < 2; w++) begin
                state_q[w] <= state_d[w];
                duty_q[w]  <= duty_d[w];
                dir_q[w]   <= dir_d[w];
                dead_q[w]  <= dead_d[w];
                motor_q[w] <= motor_d[w];
            end
        end
    end

    assign motor_l = motor_q[0];
    assign motor_r = motor_q[1];
    assign moving  = moving_q;

endmodule

// File: tb/tb_avoid_motor_drive.sv
// Bench for avoid_motor_drive: per-cycle comparison against a behavioural wheel model
// plus directed scenarios with hand-computed expectations.
module tb_avoid_motor_drive;
    localparam int P     = 100;
    localparam int FWD   = 70;
    localparam int TURN  = 50;
    localparam int STEP  = 10;
    localparam int DEADP = 3;

    logic       clk = 1'b0;
    logic       nCR = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] AvoidSignal = 2'b00;
    logic [1:0] motor_l, motor_r;
    logic       moving;

    int total = 0;
    int bad   = 0;

    // Model: cnt, per-wheel duty (%), dir (0 fwd / 1 rev), remaining dead periods, bridge active.
    int   m_cnt = 0;
    int   bnd_cnt = 0;
    int   m_duty [2] = '{0, 0};
    int   m_dir  [2] = '{0, 0};
    int   m_dead [2] = '{0, 0};
    bit   m_on   [2] = '{1'b0, 1'b0};
    logic [1:0] exp_m [2] = '{2'b00, 2'b00};
    logic exp_mov = 1'b0;

    avoid_motor_drive #(
        .CLK_FREQ(100000), .PWM_FREQ(1000), .DUTY_FWD(FWD), .DUTY_TURN(TURN),
        .RAMP_STEP(STEP), .DEAD_PERIODS(DEADP)
    ) dut (
        .clk(clk), .nCR(nCR), .enable(enable), .AvoidSignal(AvoidSignal),
        .motor_l(motor_l), .motor_r(motor_r), .moving(moving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int w = 0; w < 2; w++) begin
            m_duty[w] = 0; m_dir[w] = 0; m_dead[w] = 0; m_on[w] = 1'b0; exp_m[w] = 2'b00;
        end
        exp_mov = 1'b0;
    endtask

    // Advances the model over the coming rising edge, using the inputs the DUT will sample there.
    task automatic model_step();
        int td, tdir;
        for (int w = 0; w < 2; w++)
            exp_m[w] = (m_on[w] && m_cnt < m_duty[w] * (P / 100)) ? (m_dir[w] ? 2'b01 : 2'b10) : 2'b00;
        exp_mov = (m_duty[0] != 0) || (m_duty[1] != 0);
        if (m_cnt == P - 1) begin
            bnd_cnt++;
            for (int w = 0; w < 2; w++) begin
                if (!enable) begin
                    td = 0; tdir = m_dir[w];
                end else begin
                    td   = (AvoidSignal == 2'b00) ? FWD : TURN;
                    tdir = (w == 0) ? int'(AvoidSignal == 2'b01 || AvoidSignal == 2'b11)
                                    : int'(AvoidSignal == 2'b10 || AvoidSignal == 2'b11);
                end
                if (m_dead[w] > 0) begin
                    m_dead[w]--;
                    if (m_dead[w] == 0) begin
                        m_dir[w]  = tdir;
                        m_on[w]   = (td > 0);
                        m_duty[w] = (td > 0) ? ((STEP < td) ? STEP : td) : 0;
                    end
                end else if (!m_on[w]) begin
                    if (td > 0) begin
                        m_dir[w] = tdir; m_on[w] = 1'b1; m_duty[w] = (STEP < td) ? STEP : td;
                    end
                end else if (tdir != m_dir[w]) begin
                    m_duty[w] = (m_duty[w] > STEP) ? m_duty[w] - STEP : 0;
                    if (m_duty[w] == 0) begin
                        m_on[w] = 1'b0; m_dead[w] = DEADP;
                    end
                end else begin
                    if (m_duty[w] < td) m_duty[w] = (m_duty[w] + STEP > td) ? td : m_duty[w] + STEP;
                    else                m_duty[w] = (m_duty[w] - STEP < td) ? td : m_duty[w] - STEP;
                    if (m_duty[w] == 0) m_on[w] = 1'b0;
                end
            end
        end
        m_cnt = (m_cnt + 1) % P;
    endtask

    always @(negedge clk) begin
        if (!nCR) begin
            chk("rst_motor_l", motor_l, 2'b00);
            chk("rst_motor_r", motor_r, 2'b00);
            chk("rst_moving", moving, 1'b0);
            model_reset();
        end else begin
            chk("motor_l", motor_l, exp_m[0]);
            chk("motor_r", motor_r, exp_m[1]);
            chk("moving", moving, exp_mov);
            model_step();
        end
    end

    task automatic wait_bnd(input int n);
        for (int i = 0; i < n; i++) begin
            int start, cyc;
            start = bnd_cnt;
            cyc   = 0;
            while (bnd_cnt == start && cyc < 250) begin
                @(posedge clk);
                cyc++;
            end
            if (bnd_cnt == start) begin
                total++; bad++;
                $display("FAIL bnd_timeout: got no boundary within %0d cycles", cyc);
            end
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] cmd);
        @(posedge clk);
        #2;
        enable      = en;
        AvoidSignal = cmd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hi, lo, zl, r;
        logic in1;
        #1 nCR = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state_l", motor_l, 2'b00);
        chk("reset_state_r", motor_r, 2'b00);
        chk("reset_moving", moving, 1'b0);
        @(posedge clk); #2 nCR = 1'b1;

        // Forward soft start 10..70 then hold
        drive(1'b1, 2'b00);
        for (int i = 1; i <= 7; i++) begin
            wait_bnd(1);
            chk("fwd_ramp_l", m_duty[0], 10 * i);
            chk("fwd_ramp_r", m_duty[1], 10 * i);
        end
        wait_bnd(2);
        chk("fwd_hold", m_duty[0], 70);
        hi = 0; lo = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            hi += int'(motor_l[1]);
            lo += int'(motor_l[0]);
        end
        chk("fwd_in1_high_cycles", hi, 70);
        chk("fwd_in2_high_cycles", lo, 0);

        // Full reversal: ramp down, 3 coast periods, reverse ramp up
        drive(1'b1, 2'b11);
        for (int i = 1; i <= 7; i++) begin
            wait_bnd(1);
            chk("rev_down_l", m_duty[0], 70 - 10 * i);
        end
        zl = 0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (motor_l == 2'b00 && motor_r == 2'b00) zl++;
            else break;
        end
        chk("rev_coast_cycles", zl, 301);
        chk("rev_first_l", motor_l, 2'b01);
        chk("rev_first_r", motor_r, 2'b01);
        in1 = 1'b0;
        for (int j = 0; j < 5 * P; j++) begin
            @(negedge clk);
            in1 = in1 | motor_l[1] | motor_r[1];
        end
        chk("rev_in1_never", in1, 1'b0);
        chk("rev_duty", m_duty[0], 50);

        // Pivot left from steady forward
        drive(1'b1, 2'b00);
        wait_bnd(17);
        chk("fwd_again", m_duty[0], 70);
        drive(1'b1, 2'b01);
        wait_bnd(2);
        chk("pivot_r_duty", m_duty[1], 50);
        chk("pivot_l_down", m_duty[0], 50);
        wait_bnd(5);
        chk("pivot_l_zero", m_duty[0], 0);
        chk("pivot_r_hold", m_duty[1], 50);
        wait_bnd(3);
        chk("pivot_l_start", m_duty[0], 10);
        chk("pivot_l_dir", m_dir[0], 1);
        wait_bnd(4);
        chk("pivot_l_top", m_duty[0], 50);

        // Command reverts during dead time
        drive(1'b1, 2'b00);
        wait_bnd(17);
        drive(1'b1, 2'b11);
        wait_bnd(7);
        chk("revert_at_zero", m_duty[0], 0);
        drive(1'b1, 2'b00);
        wait_bnd(2);
        chk("revert_still_dead", m_duty[0], 0);
        wait_bnd(1);
        chk("revert_resume", m_duty[0], 10);
        chk("revert_dir", m_dir[0], 0);

        // Disable: ramp to stop, moving drops one cycle later
        wait_bnd(7);
        drive(1'b0, 2'b00);
        wait_bnd(7);
        chk("stop_duty_l", m_duty[0], 0);
        chk("stop_duty_r", m_duty[1], 0);
        @(negedge clk);
        chk("stop_moving_lag", moving, 1'b1);
        @(negedge clk);
        chk("stop_moving_off", moving, 1'b0);

        // Async reset mid-ramp
        drive(1'b1, 2'b00);
        wait_bnd(3);
        repeat (5) @(negedge clk);
        chk("pre_reset_l", motor_l, 2'b10);
        enable = 1'b0;
        #3 nCR = 1'b0;
        #1;
        chk("async_rst_l", motor_l, 2'b00);
        chk("async_rst_r", motor_r, 2'b00);
        chk("async_rst_moving", moving, 1'b0);
        repeat (3) @(posedge clk);
        #2 nCR = 1'b1;

        // Command toggling inside one period: only the value at cnt=99 counts
        wait_bnd(1);
        for (int k = 1; k <= 98; k++) begin
            @(posedge clk); #2;
            enable = 1'b1;
            r = $urandom_range(0, 2);
            AvoidSignal = (r == 2) ? 2'b11 : 2'(r);
        end
        @(posedge clk); #2 AvoidSignal = 2'b10;
        wait_bnd(1);
        chk("toggle_dir_l", m_dir[0], 0);
        chk("toggle_dir_r", m_dir[1], 1);
        chk("toggle_duty_r", m_duty[1], 10);
        repeat (3) @(negedge clk);
        chk("toggle_out_l", motor_l, 2'b10);
        chk("toggle_out_r", motor_r, 2'b01);

        // Random commands and enables
        for (int it = 0; it < 40; it++) begin
            drive($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)));
            repeat ($urandom_range(1, 400)) @(posedge clk);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
